// File: rtl/wish_pack.sv
// -----------------------------------------------------------------------------
// wish_pack
//
// Wishbone-style packing stage. Collects NUM_PACK narrow DATA_WIDTH-bit words
// from the source bus and presents them as one wide word on the destination
// bus. Frame markers travel on tgc: bit 0 = start-of-frame, bit 1 = end-of-frame.
// The wide tgc is the OR of all narrow tgc values in the group.
//
// The assembly register (narrow side) and the output register (wide side) are
// independent, so a new group can be collected while the previous wide word is
// still waiting for d_ack_i. Only when a second group completes while the
// output register is still occupied does the source get stalled (HOLD).
//
// Optional feature macro: WISH_PACK_FLUSH_EN
//   defined   : a source word with EOF closes the group at once; unused slots
//               are filled with PAD_VALUE.
//   undefined : groups always contain exactly NUM_PACK words; EOF is only
//               ORed into d_tgc_o[1].
//
// Parameters
//   DATA_WIDTH    narrow word width
//   NUM_PACK      narrow words per wide word (>= 2)
//   LITTLE_ENDIAN 1: k-th word at the low end, 0: k-th word at the high end
//   PAD_VALUE     fill for unused slots of a flushed short group
//
// Ports
//   clk_i      clock, rising edge
//   rst_n_i    synchronous active-low reset; forces all outputs low while 0
//   s_stb_i    source strobe
//   s_cyc_i    source cycle
//   s_ack_o    source acknowledge (combinational)
//   s_stall_o  source stall (!s_ack_o while out of reset)
//   s_dat_i    narrow data
//   s_tgc_i    narrow frame markers {EOF, SOF}
//   d_stb_o    destination strobe
//   d_cyc_o    destination cycle (same as d_stb_o)
//   d_ack_i    destination acknowledge
//   d_dat_o    packed wide data
//   d_tgc_o    OR of the group's frame markers
// -----------------------------------------------------------------------------
module wish_pack #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    NUM_PACK      = 4,
    parameter int                    LITTLE_ENDIAN = 1,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           s_stb_i,
    input  logic                           s_cyc_i,
    output logic                           s_ack_o,
    output logic                           s_stall_o,
    input  logic [DATA_WIDTH-1:0]          s_dat_i,
    input  logic [1:0]                     s_tgc_i,
    output logic                           d_stb_o,
    output logic                           d_cyc_o,
    input  logic                           d_ack_i,
    output logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o,
    output logic [1:0]                     d_tgc_o
);

    localparam int CW = $clog2(NUM_PACK) + 1;
    localparam int WW = DATA_WIDTH * NUM_PACK;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   asm_buf_q [NUM_PACK];
    logic [DATA_WIDTH-1:0]   asm_buf_d [NUM_PACK];
    logic [1:0]              asm_tgc_q, asm_tgc_d;
    logic [WW-1:0]           out_buf_q, out_buf_d;
    logic [1:0]              out_tgc_q, out_tgc_d;
    logic                    out_valid_q, out_valid_d;

    // ------------------------------------------------------------ datapath
    logic                    held;
    logic                    src_beat;
    logic                    dst_beat;
    logic                    out_free;
    logic                    eof_flush;
    logic                    group_done;
    logic [DATA_WIDTH-1:0]   group_l [NUM_PACK];  // group in arrival order
    logic [WW-1:0]           group_wide;          // group mapped to bus order
    logic [WW-1:0]           held_wide;           // held group mapped to bus order

    assign held     = (state_q == ST_HOLD);
    assign s_ack_o  = rst_n_i && !held;
    assign s_stall_o = rst_n_i && held;
    assign src_beat = s_stb_i && s_cyc_i && s_ack_o;
    assign dst_beat = out_valid_q && d_ack_i;
    assign out_free = !out_valid_q || d_ack_i;

`ifdef WISH_PACK_FLUSH_EN
    assign eof_flush = s_tgc_i[1];
`else
    assign eof_flush = 1'b0;
`endif

    assign group_done = (cnt_q == CW'(NUM_PACK - 1)) || eof_flush;

    // Slots before cnt come from the assembly register, slot cnt takes the
    // incoming word, and later slots get PAD_VALUE. On a full group the pad
    // branch is never selected; on a non-completing beat the padded slots are
    // simply overwritten by later words.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PACK; gi++) begin : g_slot
            localparam int PHYS = (LITTLE_ENDIAN != 0) ? gi : (NUM_PACK - 1 - gi);

            assign group_l[gi] = (CW'(gi) < cnt_q)  ? asm_buf_q[gi] :
                                 (CW'(gi) == cnt_q) ? s_dat_i       :
                                                      PAD_VALUE;

            assign group_wide[PHYS*DATA_WIDTH +: DATA_WIDTH] = group_l[gi];
            assign held_wide[PHYS*DATA_WIDTH +: DATA_WIDTH]  = asm_buf_q[gi];
        end
    endgenerate

    // ------------------------------------------------------- next state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_buf_d   = asm_buf_q;
        asm_tgc_d   = asm_tgc_q;
        out_buf_d   = out_buf_q;
        out_tgc_d   = out_tgc_q;
        out_valid_d = out_valid_q;

        // Default drain of the output register; a load below overrides it.
        if (dst_beat) begin
            out_valid_d = 1'b0;
        end

        // A held group moves into the output register on the same edge
        // that retires the previous wide word.
        if (held && dst_beat) begin
            out_buf_d   = held_wide;
            out_tgc_d   = asm_tgc_q;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            asm_tgc_d   = '0;
            state_d     = ST_FILL;
        end

        // src_beat is impossible in HOLD since s_ack_o is low there.
        if (src_beat) begin
            asm_buf_d = group_l;
            if (group_done) begin
                if (out_free) begin
                    out_buf_d   = group_wide;
                    out_tgc_d   = asm_tgc_q | s_tgc_i;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    asm_tgc_d   = '0;
                end else begin
                    // Keep the completed (padded) group in the assembly
                    // register until the output register frees up.
                    asm_tgc_d = asm_tgc_q | s_tgc_i;
                    state_d   = ST_HOLD;
                end
            end else begin
                asm_tgc_d = asm_tgc_q | s_tgc_i;
                cnt_d     = cnt_q + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            asm_tgc_q   <= '0;
            out_buf_q   <= '0;
            out_tgc_q   <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < NUM_PACK; k++) begin
                asm_buf_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_tgc_q   <= asm_tgc_d;
            out_buf_q   <= out_buf_d;
            out_tgc_q   <= out_tgc_d;
            out_valid_q <= out_valid_d;
            asm_buf_q   <= asm_buf_d;
        end
    end

    // ------------------------------------------------------------- outputs
    // Destination outputs are forced low while reset is asserted.
    assign d_stb_o = rst_n_i && out_valid_q;
    assign d_cyc_o = d_stb_o;
    assign d_dat_o = rst_n_i ? out_buf_q : '0;
    assign d_tgc_o = rst_n_i ? out_tgc_q : 2'b00;

endmodule

// File: tb/tb_wish_pack.sv
// -----------------------------------------------------------------------------
// Testbench for wish_pack. Two instances share the source-side stimulus and
// d_ack_i: one little-endian, one big-endian, both with PAD_VALUE = 0xEE.
// Each test pushes the wide words it expects into per-instance scoreboards;
// a monitor on the falling edge pops and compares on every destination beat.
// -----------------------------------------------------------------------------
module tb_wish_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_stb;
    logic        s_cyc;
    logic [7:0]  s_dat;
    logic [1:0]  s_tgc;
    logic        d_ack;

    logic        s_ack_le, s_stall_le, d_stb_le, d_cyc_le;
    logic [31:0] d_dat_le;
    logic [1:0]  d_tgc_le;
    logic        s_ack_be, s_stall_be, d_stb_be, d_cyc_be;
    logic [31:0] d_dat_be;
    logic [1:0]  d_tgc_be;

    int checks = 0;
    int errors = 0;

    // {tgc, dat}
    logic [33:0] sb_le [$];
    logic [33:0] sb_be [$];

    always #5 clk = ~clk;

    wish_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .LITTLE_ENDIAN(1), .PAD_VALUE(8'hEE)) dut_le (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(s_ack_le), .s_stall_o(s_stall_le),
        .s_dat_i(s_dat), .s_tgc_i(s_tgc),
        .d_stb_o(d_stb_le), .d_cyc_o(d_cyc_le), .d_ack_i(d_ack),
        .d_dat_o(d_dat_le), .d_tgc_o(d_tgc_le)
    );

    wish_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .LITTLE_ENDIAN(0), .PAD_VALUE(8'hEE)) dut_be (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(s_ack_be), .s_stall_o(s_stall_be),
        .s_dat_i(s_dat), .s_tgc_i(s_tgc),
        .d_stb_o(d_stb_be), .d_cyc_o(d_cyc_be), .d_ack_i(d_ack),
        .d_dat_o(d_dat_be), .d_tgc_o(d_tgc_be)
    );

    // Inputs change only at posedge+1, so at the falling edge a strobe with
    // ack means a destination beat at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && d_ack && d_stb_le) begin
            checks++;
            if (sb_le.size() == 0) begin
                errors++;
                $display("FAIL le_unexpected: got dat=%h tgc=%b, no word expected", d_dat_le, d_tgc_le);
            end else begin
                logic [33:0] e;
                e = sb_le.pop_front();
                if ({d_tgc_le, d_dat_le} !== e || d_cyc_le !== 1'b1) begin
                    errors++;
                    $display("FAIL le_word: got tgc=%b dat=%h cyc=%b, expected tgc=%b dat=%h cyc=1",
                             d_tgc_le, d_dat_le, d_cyc_le, e[33:32], e[31:0]);
                end else begin
                    $display("le beat: dat=%h tgc=%b", d_dat_le, d_tgc_le);
                end
            end
        end
        if (rst_n && d_ack && d_stb_be) begin
            checks++;
            if (sb_be.size() == 0) begin
                errors++;
                $display("FAIL be_unexpected: got dat=%h tgc=%b, no word expected", d_dat_be, d_tgc_be);
            end else begin
                logic [33:0] e;
                e = sb_be.pop_front();
                if ({d_tgc_be, d_dat_be} !== e || d_cyc_be !== 1'b1) begin
                    errors++;
                    $display("FAIL be_word: got tgc=%b dat=%h cyc=%b, expected tgc=%b dat=%h cyc=1",
                             d_tgc_be, d_dat_be, d_cyc_be, e[33:32], e[31:0]);
                end else begin
                    $display("be beat: dat=%h tgc=%b", d_dat_be, d_tgc_be);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] le, input logic [31:0] be, input logic [1:0] tgc);
        sb_le.push_back({tgc, le});
        sb_be.push_back({tgc, be});
    endtask

    // Present one word and hold it until the source beat happens.
    task automatic send(input logic [7:0] d, input logic [1:0] t, output int waits);
        int n;
        s_stb = 1'b1;
        s_cyc = 1'b1;
        s_dat = d;
        s_tgc = t;
        n = 0;
        @(negedge clk);
        while (!s_ack_le && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h never acknowledged", d);
        end
        waits = n;
        @(posedge clk);
        #1;
        s_stb = 1'b0;
        s_cyc = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_le.size() != 0 || sb_be.size() != 0) && n < 200) begin
            n++;
            next_cycle();
        end
        checks++;
        if (sb_le.size() != 0 || sb_be.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d/%0d words still pending, expected 0/0", name, sb_le.size(), sb_be.size());
        end
        repeat (3) next_cycle();
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({s_ack_le, s_stall_le, d_stb_le, d_cyc_le, d_dat_le, d_tgc_le} !== 38'd0 ||
            {s_ack_be, s_stall_be, d_stb_be, d_cyc_be, d_dat_be, d_tgc_be} !== 38'd0) begin
            errors++;
            $display("FAIL %s: got le ack=%b stall=%b stb=%b cyc=%b dat=%h tgc=%b, be stb=%b dat=%h, expected all 0",
                     name, s_ack_le, s_stall_le, d_stb_le, d_cyc_le, d_dat_le, d_tgc_le, d_stb_be, d_dat_be);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) next_cycle();
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_ack_le !== 1'b1 || s_stall_le !== 1'b0 || d_stb_le !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ack=%b stall=%b stb=%b, expected 1 0 0", s_ack_le, s_stall_le, d_stb_le);
        end
        next_cycle();
    endtask

    task automatic test_full_group();
        int w;
        d_ack = 1'b1;
        expect_word(32'h44332211, 32'h11223344, 2'b01);
        send(8'h11, 2'b01, w);
        send(8'h22, 2'b00, w);
        send(8'h33, 2'b00, w);
        send(8'h44, 2'b00, w);
        checks++;
        if (d_stb_le !== 1'b1 || d_dat_le !== 32'h44332211 || d_tgc_le !== 2'b01 || d_dat_be !== 32'h11223344) begin
            errors++;
            $display("FAIL full_latency: got stb=%b dat=%h tgc=%b be=%h, expected 1 44332211 01 11223344",
                     d_stb_le, d_dat_le, d_tgc_le, d_dat_be);
        end
        next_cycle();
        checks++;
        if (d_stb_le !== 1'b0 || d_stb_be !== 1'b0) begin
            errors++;
            $display("FAIL full_one_cycle: got stb=%b/%b, expected 0/0", d_stb_le, d_stb_be);
        end
        wait_drain("full");
    endtask

    task automatic test_backpressure();
        int w;
        d_ack = 1'b0;
        expect_word(32'h44332211, 32'h11223344, 2'b00);
        expect_word(32'h88776655, 32'h55667788, 2'b00);
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] d;
            d = 8'(i * 8'h11);
            send(d, 2'b00, w);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (s_ack_le !== 1'b0 || s_stall_le !== 1'b1 || d_dat_le !== 32'h44332211 || d_stb_le !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: got ack=%b stall=%b stb=%b dat=%h, expected 0 1 1 44332211",
                         s_ack_le, s_stall_le, d_stb_le, d_dat_le);
            end
            next_cycle();
        end
        d_ack = 1'b1;
        next_cycle();
        d_ack = 1'b0;
        checks++;
        if (d_dat_le !== 32'h88776655 || d_dat_be !== 32'h55667788 || d_stb_le !== 1'b1 || s_ack_le !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got dat=%h be=%h stb=%b ack=%b, expected 88776655 55667788 1 1",
                     d_dat_le, d_dat_be, d_stb_le, s_ack_le);
        end
        next_cycle();
        d_ack = 1'b1;
        wait_drain("bp");
    endtask

    task automatic test_flush();
        int w;
        d_ack = 1'b1;
`ifdef WISH_PACK_FLUSH_EN
        expect_word(32'hEEEEA2A1, 32'hA1A2EEEE, 2'b10);
        send(8'hA1, 2'b00, w);
        send(8'hA2, 2'b10, w);
        checks++;
        if (d_stb_le !== 1'b1 || d_dat_le !== 32'hEEEEA2A1 || d_tgc_le !== 2'b10) begin
            errors++;
            $display("FAIL flush_word: got stb=%b dat=%h tgc=%b, expected 1 EEEEA2A1 10", d_stb_le, d_dat_le, d_tgc_le);
        end
`else
        expect_word(32'hA4A3A2A1, 32'hA1A2A3A4, 2'b10);
        send(8'hA1, 2'b00, w);
        send(8'hA2, 2'b10, w);
        repeat (3) begin
            checks++;
            if (d_stb_le !== 1'b0) begin
                errors++;
                $display("FAIL noflush_idle: got stb=%b dat=%h, expected stb 0", d_stb_le, d_dat_le);
            end
            next_cycle();
        end
        send(8'hA3, 2'b00, w);
        send(8'hA4, 2'b00, w);
`endif
        wait_drain("flush");
    endtask

    task automatic test_back_to_back();
        int w;
        int stalls;
        logic [7:0] wd [12];
        d_ack = 1'b1;
        stalls = 0;
        for (int i = 0; i < 12; i++) wd[i] = 8'($urandom_range(0, 255));
        for (int g = 0; g < 3; g++) begin
            logic [1:0] t;
            t = (g == 0) ? 2'b01 : (g == 2) ? 2'b10 : 2'b00;
            expect_word({wd[4*g+3], wd[4*g+2], wd[4*g+1], wd[4*g]},
                        {wd[4*g], wd[4*g+1], wd[4*g+2], wd[4*g+3]}, t);
        end
        for (int i = 0; i < 12; i++) begin
            logic [1:0] t;
            t = (i == 0) ? 2'b01 : (i == 11) ? 2'b10 : 2'b00;
            send(wd[i], t, w);
            stalls += w;
        end
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL b2b_stall: got %0d stall cycles, expected 0", stalls);
        end
        wait_drain("b2b");
    endtask

    task automatic test_reset_mid();
        int w;
        d_ack = 1'b0;
        // A pending wide word plus a partial group, both to be discarded.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            d = 8'(8'h51 + i);
            send(d, 2'b01, w);
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset_outputs");
        next_cycle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (d_stb_le !== 1'b0 || s_ack_le !== 1'b1) begin
            errors++;
            $display("FAIL midreset_discard: got stb=%b ack=%b, expected 0 1", d_stb_le, s_ack_le);
        end
        d_ack = 1'b1;
        expect_word(32'h34333231, 32'h31323334, 2'b00);
        send(8'h31, 2'b00, w);
        send(8'h32, 2'b00, w);
        send(8'h33, 2'b00, w);
        send(8'h34, 2'b00, w);
        wait_drain("midreset");
    endtask

    initial begin
        rst_n = 1'b0;
        s_stb = 1'b0;
        s_cyc = 1'b0;
        s_dat = '0;
        s_tgc = '0;
        d_ack = 1'b0;
        next_cycle();
        test_reset();
        test_full_group();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
